// File: rtl/lcd_id_pkg.sv
// Shared constants for the LCD panel ID probe: panel ID codes, probe opcodes,
// expected match bytes, FSM state encodings and small lookup helpers.
package lcd_id_pkg;

    // Panel ID codes published on lcd_id
    localparam logic [15:0] LCD_ID_9341 = 16'h9341;
    localparam logic [15:0] LCD_ID_5310 = 16'h5310;
    localparam logic [15:0] LCD_ID_5510 = 16'h5510;
    localparam logic [15:0] LCD_ID_1963 = 16'h1963;
    localparam logic [15:0] LCD_ID_NONE = 16'h0000;

    // ID-read opcodes, one per probe, issued in this order
    localparam logic [15:0] OP_P0 = 16'h00D3;
    localparam logic [15:0] OP_P1 = 16'h00D4;
    localparam logic [15:0] OP_P2 = 16'hDB00;
    localparam logic [15:0] OP_P3 = 16'h00A1;

    // Number of parameter reads following each opcode
    localparam logic [2:0] NRD_P0 = 3'd4;
    localparam logic [2:0] NRD_P1 = 3'd4;
    localparam logic [2:0] NRD_P2 = 3'd1;
    localparam logic [2:0] NRD_P3 = 3'd5;

    // Match bytes (parameter bytes numbered from 1)
    localparam logic [7:0] P0_B3 = 8'h93;
    localparam logic [7:0] P0_B4 = 8'h41;
    localparam logic [7:0] P1_B3 = 8'h53;
    localparam logic [7:0] P1_B4 = 8'h10;
    localparam logic [7:0] P2_B1 = 8'h80;
    localparam logic [7:0] P3_B3 = 8'h61;
    localparam logic [7:0] P3_B4 = 8'h01;

    localparam logic [1:0] LAST_PROBE = 2'd3;

    // Probe sequencer states; ST_GAP is only reachable when retries are built in
    typedef enum logic [2:0] {
        ST_PWRUP  = 3'd0,
        ST_CMD_WR = 3'd1,
        ST_RD     = 3'd2,
        ST_EVAL   = 3'd3,
        ST_GAP    = 3'd4,
        ST_DONE   = 3'd5
    } probe_state_t;

    // Single bus-cycle engine states
    typedef enum logic [2:0] {
        XF_IDLE  = 3'd0,
        XF_WLOW  = 3'd1,
        XF_WHIGH = 3'd2,
        XF_RLOW  = 3'd3,
        XF_RHIGH = 3'd4
    } xfer_state_t;

    function automatic logic [15:0] probe_opcode(input logic [1:0] p);
        case (p)
            2'd0:    return OP_P0;
            2'd1:    return OP_P1;
            2'd2:    return OP_P2;
            default: return OP_P3;
        endcase
    endfunction

    function automatic logic [2:0] probe_reads(input logic [1:0] p);
        case (p)
            2'd0:    return NRD_P0;
            2'd1:    return NRD_P1;
            2'd2:    return NRD_P2;
            default: return NRD_P3;
        endcase
    endfunction

    function automatic logic [15:0] probe_code(input logic [1:0] p);
        case (p)
            2'd0:    return LCD_ID_9341;
            2'd1:    return LCD_ID_5310;
            2'd2:    return LCD_ID_5510;
            default: return LCD_ID_1963;
        endcase
    endfunction

    // True when the captured bytes identify the panel targeted by probe p
    function automatic logic probe_match(input logic [1:0] p, input logic [7:0] b1,
                                         input logic [7:0] b3, input logic [7:0] b4);
        case (p)
            2'd0:    return (b3 == P0_B3) && (b4 == P0_B4);
            2'd1:    return (b3 == P1_B3) && (b4 == P1_B4);
            2'd2:    return (b1 == P2_B1);
            default: return (b3 == P3_B3) && (b4 == P3_B4);
        endcase
    endfunction

endpackage

// File: rtl/lcd_id_reader_if.sv
// 8080-style 16-bit LCD bus. master = the controller driving strobes,
// slave = the panel (or its model) driving the read data.
interface lcd_id_reader_if;
    logic [15:0] lcd_data_in;
    logic [15:0] lcd_data_out;
    logic        lcd_data_oe;
    logic        lcd_cs_n;
    logic        lcd_rs;
    logic        lcd_wr_n;
    logic        lcd_rd_n;

    modport master (
        input  lcd_data_in,
        output lcd_data_out,
        output lcd_data_oe,
        output lcd_cs_n,
        output lcd_rs,
        output lcd_wr_n,
        output lcd_rd_n
    );

    modport slave (
        output lcd_data_in,
        input  lcd_data_out,
        input  lcd_data_oe,
        input  lcd_cs_n,
        input  lcd_rs,
        input  lcd_wr_n,
        input  lcd_rd_n
    );
endinterface

// File: rtl/lcd_8080_xfer.sv
// One 8080 bus cycle: a write (wr_n low/high with data driven) or a read
// (rd_n low/high with the low data byte captured on the last low cycle).
// start is accepted only while idle; done pulses in the last high cycle.
module lcd_8080_xfer
    import lcd_id_pkg::*;
#(
    parameter int WR_LOW_CYC  = 2,
    parameter int WR_HIGH_CYC = 2,
    parameter int RD_LOW_CYC  = 10,
    parameter int RD_HIGH_CYC = 5
) (
    input  logic        clk_50m,
    input  logic        rst_n,
    input  logic        start,
    input  logic        rnw,
    input  logic [15:0] wdata,
    output logic        done,
    output logic [7:0]  rdata,
    output logic        wr_n,
    output logic        rd_n,
    output logic        data_oe,
    output logic [15:0] data_out,
    input  logic [7:0]  data_in
);

    localparam int MAX_AB  = (WR_LOW_CYC > WR_HIGH_CYC) ? WR_LOW_CYC : WR_HIGH_CYC;
    localparam int MAX_CD  = (RD_LOW_CYC > RD_HIGH_CYC) ? RD_LOW_CYC : RD_HIGH_CYC;
    localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] WL_LAST = CNT_W'(WR_LOW_CYC - 1);
    localparam logic [CNT_W-1:0] WH_LAST = CNT_W'(WR_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] RL_LAST = CNT_W'(RD_LOW_CYC - 1);
    localparam logic [CNT_W-1:0] RH_LAST = CNT_W'(RD_HIGH_CYC - 1);

    xfer_state_t      state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             wr_n_reg, rd_n_reg, oe_reg, oe_next;
    logic [15:0]      data_out_reg;
    logic [7:0]       rdata_reg;

    // Phase sequencing: the cycle counter restarts at every phase entry
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + 1'b1;
        done       = 1'b0;
        case (state_reg)
            XF_IDLE: begin
                cnt_next = '0;
                if (start) begin
                    state_next = rnw ? XF_RLOW : XF_WLOW;
                end
            end
            XF_WLOW: begin
                if (cnt_reg == WL_LAST) begin
                    state_next = XF_WHIGH;
                    cnt_next   = '0;
                end
            end
            XF_WHIGH: begin
                if (cnt_reg == WH_LAST) begin
                    state_next = XF_IDLE;
                    cnt_next   = '0;
                    done       = 1'b1;
                end
            end
            XF_RLOW: begin
                if (cnt_reg == RL_LAST) begin
                    state_next = XF_RHIGH;
                    cnt_next   = '0;
                end
            end
            XF_RHIGH: begin
                if (cnt_reg == RH_LAST) begin
                    state_next = XF_IDLE;
                    cnt_next   = '0;
                    done       = 1'b1;
                end
            end
            default: begin
                state_next = XF_IDLE;
                cnt_next   = '0;
            end
        endcase
        // Keep driving through the first high cycle so data holds past the wr_n rising edge
        oe_next = (state_next == XF_WLOW) ||
                  ((state_reg == XF_WLOW) && (state_next == XF_WHIGH));
    end

    // State and counter registers; reset drops every strobe immediately
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= XF_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Registered pad outputs derived from the upcoming phase, plus read capture
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            wr_n_reg     <= 1'b1;
            rd_n_reg     <= 1'b1;
            oe_reg       <= 1'b0;
            data_out_reg <= '0;
            rdata_reg    <= '0;
        end else begin
            wr_n_reg <= (state_next != XF_WLOW);
            rd_n_reg <= (state_next != XF_RLOW);
            oe_reg   <= oe_next;
            if ((state_reg == XF_IDLE) && start && !rnw) begin
                data_out_reg <= wdata;
            end else if (!oe_next) begin
                data_out_reg <= '0;
            end
            if ((state_reg == XF_RLOW) && (cnt_reg == RL_LAST)) begin
                rdata_reg <= data_in;
            end
        end
    end

    assign wr_n     = wr_n_reg;
    assign rd_n     = rd_n_reg;
    assign data_oe  = oe_reg;
    assign data_out = data_out_reg;
    assign rdata    = rdata_reg;

endmodule

// File: rtl/lcd_id_reader.sv
// Power-up LCD panel identification. Waits PWRUP_CYC cycles, then runs the
// probe sequence (0xD3, 0xD4, 0xDB00, 0xA1), matches the returned parameter
// bytes and publishes lcd_id / id_valid / id_err. The bus is released once
// id_valid is set. Build option LCD_ID_RETRY_EN repeats the whole pass up to
// RETRY_MAX times before reporting failure.
module lcd_id_reader
    import lcd_id_pkg::*;
#(
    parameter int PWRUP_CYC   = 2_500_000,
    parameter int WR_LOW_CYC  = 2,
    parameter int WR_HIGH_CYC = 2,
    parameter int RD_LOW_CYC  = 10,
    parameter int RD_HIGH_CYC = 5
`ifdef LCD_ID_RETRY_EN
    ,
    parameter int RETRY_MAX   = 3
`endif
) (
    input  logic                   clk_50m,
    input  logic                   rst_n,
    lcd_id_reader_if.master        bus,
    output logic [15:0]            lcd_id,
    output logic                   id_valid,
    output logic                   id_err
);

    localparam int WAIT_MAX = (PWRUP_CYC > WR_HIGH_CYC) ? PWRUP_CYC : WR_HIGH_CYC;
    localparam int WAIT_W   = $clog2(WAIT_MAX) + 1;
    localparam logic [WAIT_W-1:0] PW_LAST = WAIT_W'(PWRUP_CYC - 1);
`ifdef LCD_ID_RETRY_EN
    localparam logic [WAIT_W-1:0] GAP_LAST  = WAIT_W'(WR_HIGH_CYC - 1);
    localparam int                PASS_W    = $clog2(RETRY_MAX) + 1;
    localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(RETRY_MAX - 1);
`endif

    probe_state_t      state_reg, state_next;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic [1:0]        probe_reg, probe_next;
    logic [2:0]        rd_idx_reg, rd_idx_next;
    logic              issued_reg, issued_next;
    logic [7:0]        b1_reg, b1_next, b3_reg, b3_next, b4_reg, b4_next;
    logic [15:0]       id_reg, id_next;
    logic              valid_reg, valid_next, err_reg, err_next;
    logic              cs_n_reg, rs_reg;
`ifdef LCD_ID_RETRY_EN
    logic [PASS_W-1:0] pass_reg, pass_next;
`endif

    logic              xfer_start, xfer_rnw, xfer_done;
    logic [7:0]        xfer_rdata;

    // Only the low data byte carries ID parameters
    logic unused_data_hi;
    assign unused_data_hi = ^bus.lcd_data_in[15:8];

    lcd_8080_xfer #(
        .WR_LOW_CYC  (WR_LOW_CYC),
        .WR_HIGH_CYC (WR_HIGH_CYC),
        .RD_LOW_CYC  (RD_LOW_CYC),
        .RD_HIGH_CYC (RD_HIGH_CYC)
    ) u_xfer (
        .clk_50m  (clk_50m),
        .rst_n    (rst_n),
        .start    (xfer_start),
        .rnw      (xfer_rnw),
        .wdata    (probe_opcode(probe_reg)),
        .done     (xfer_done),
        .rdata    (xfer_rdata),
        .wr_n     (bus.lcd_wr_n),
        .rd_n     (bus.lcd_rd_n),
        .data_oe  (bus.lcd_data_oe),
        .data_out (bus.lcd_data_out),
        .data_in  (bus.lcd_data_in[7:0])
    );

    // Probe sequencer: next state, read bookkeeping, match and result latching
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg + 1'b1;
        probe_next    = probe_reg;
        rd_idx_next   = rd_idx_reg;
        issued_next   = issued_reg;
        b1_next       = b1_reg;
        b3_next       = b3_reg;
        b4_next       = b4_reg;
        id_next       = id_reg;
        valid_next    = valid_reg;
        err_next      = err_reg;
        xfer_start    = 1'b0;
        xfer_rnw      = 1'b0;
`ifdef LCD_ID_RETRY_EN
        pass_next     = pass_reg;
`endif
        case (state_reg)
            ST_PWRUP: begin
                if (wait_cnt_reg == PW_LAST) begin
                    state_next    = ST_CMD_WR;
                    wait_cnt_next = '0;
                end
            end
            ST_CMD_WR: begin
                wait_cnt_next = '0;
                xfer_start    = !issued_reg;
                if (!issued_reg) begin
                    issued_next = 1'b1;
                end
                if (xfer_done) begin
                    issued_next = 1'b0;
                    rd_idx_next = '0;
                    state_next  = ST_RD;
                end
            end
            ST_RD: begin
                wait_cnt_next = '0;
                xfer_start    = !issued_reg;
                xfer_rnw      = 1'b1;
                if (!issued_reg) begin
                    issued_next = 1'b1;
                end
                if (xfer_done) begin
                    issued_next = 1'b0;
                    case (rd_idx_reg)
                        3'd0:    b1_next = xfer_rdata;
                        3'd2:    b3_next = xfer_rdata;
                        3'd3:    b4_next = xfer_rdata;
                        default: ;
                    endcase
                    if (rd_idx_reg == probe_reads(probe_reg) - 3'd1) begin
                        state_next = ST_EVAL;
                    end else begin
                        rd_idx_next = rd_idx_reg + 3'd1;
                    end
                end
            end
            ST_EVAL: begin
                wait_cnt_next = '0;
                b1_next       = '0;
                b3_next       = '0;
                b4_next       = '0;
                if (probe_match(probe_reg, b1_reg, b3_reg, b4_reg)) begin
                    id_next    = probe_code(probe_reg);
                    valid_next = 1'b1;
                    state_next = ST_DONE;
                end else if (probe_reg != LAST_PROBE) begin
                    probe_next = probe_reg + 2'd1;
                    state_next = ST_CMD_WR;
                end else begin
`ifdef LCD_ID_RETRY_EN
                    if (pass_reg == PASS_LAST) begin
                        id_next    = LCD_ID_NONE;
                        valid_next = 1'b1;
                        err_next   = 1'b1;
                        state_next = ST_DONE;
                    end else begin
                        pass_next  = pass_reg + 1'b1;
                        probe_next = '0;
                        state_next = ST_GAP;
                    end
`else
                    id_next    = LCD_ID_NONE;
                    valid_next = 1'b1;
                    err_next   = 1'b1;
                    state_next = ST_DONE;
`endif
                end
            end
`ifdef LCD_ID_RETRY_EN
            ST_GAP: begin
                if (wait_cnt_reg == GAP_LAST) begin
                    wait_cnt_next = '0;
                    state_next    = ST_CMD_WR;
                end
            end
`endif
            ST_DONE: begin
                wait_cnt_next = '0;
            end
            default: begin
                wait_cnt_next = '0;
                state_next    = ST_PWRUP;
            end
        endcase
    end

    // Sequencer state and result registers
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_PWRUP;
            wait_cnt_reg <= '0;
            probe_reg    <= '0;
            rd_idx_reg   <= '0;
            issued_reg   <= 1'b0;
            b1_reg       <= '0;
            b3_reg       <= '0;
            b4_reg       <= '0;
            id_reg       <= LCD_ID_NONE;
            valid_reg    <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            probe_reg    <= probe_next;
            rd_idx_reg   <= rd_idx_next;
            issued_reg   <= issued_next;
            b1_reg       <= b1_next;
            b3_reg       <= b3_next;
            b4_reg       <= b4_next;
            id_reg       <= id_next;
            valid_reg    <= valid_next;
            err_reg      <= err_next;
        end
    end

`ifdef LCD_ID_RETRY_EN
    // Count completed probe passes
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            pass_reg <= '0;
        end else begin
            pass_reg <= pass_next;
        end
    end
`endif

    // Chip select spans a whole probe pass; rs is low only for the opcode write
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            cs_n_reg <= 1'b1;
            rs_reg   <= 1'b1;
        end else begin
            cs_n_reg <= !(state_next inside {ST_CMD_WR, ST_RD, ST_EVAL});
            rs_reg   <= (state_next != ST_CMD_WR);
        end
    end

    assign bus.lcd_cs_n = cs_n_reg;
    assign bus.lcd_rs   = rs_reg;
    assign lcd_id       = id_reg;
    assign id_valid     = valid_reg;
    assign id_err       = err_reg;

endmodule

// File: tb/tb_lcd_id_reader.sv
// Bench for lcd_id_reader: a panel model answers ID reads per scenario, the
// expected outcome of each run is queued when the run is started and checked
// when id_valid rises; strobe widths are collected and checked per run.
module tb_lcd_id_reader;

    localparam int PWRUP_CYC   = 10;
    localparam int WR_LOW_CYC  = 2;
    localparam int WR_HIGH_CYC = 2;
    localparam int RD_LOW_CYC  = 10;
    localparam int RD_HIGH_CYC = 5;
`ifdef LCD_ID_RETRY_EN
    localparam int PASSES = 3;
`else
    localparam int PASSES = 1;
`endif

    localparam int M_D3  = 0;
    localparam int M_A1  = 1;
    localparam int M_DB  = 2;
    localparam int M_FLT = 3;

    typedef struct {
        string       name;
        logic [15:0] id;
        logic        err;
        int          xfers;
        logic [15:0] last_op;
        logic        d4;
    } exp_t;

    logic        clk_50m;
    logic        rst_n;
    logic [15:0] lcd_id;
    logic        id_valid;
    logic        id_err;
    int          mode;
    int          total;
    int          bad;

    // Panel model / bus observer state
    logic [15:0] cur_op;
    int          rd_idx;
    int          xfers;
    logic        seen_d4;
    int          wr_low, rd_low;
    logic        oe_in_rd, wr_prev, rd_prev;
    int          wr_w_q[$];
    int          rd_w_q[$];
    logic        rd_oe_q[$];
    exp_t        sb_q[$];

    lcd_id_reader_if bus ();

    lcd_id_reader #(
        .PWRUP_CYC   (PWRUP_CYC),
        .WR_LOW_CYC  (WR_LOW_CYC),
        .WR_HIGH_CYC (WR_HIGH_CYC),
        .RD_LOW_CYC  (RD_LOW_CYC),
        .RD_HIGH_CYC (RD_HIGH_CYC)
    ) dut (
        .clk_50m  (clk_50m),
        .rst_n    (rst_n),
        .bus      (bus),
        .lcd_id   (lcd_id),
        .id_valid (id_valid),
        .id_err   (id_err)
    );

    initial clk_50m = 1'b0;
    always #10 clk_50m = ~clk_50m;

    function automatic logic [7:0] resp_byte(input int m, input logic [15:0] op, input int idx);
        logic [7:0] r;
        r = 8'hFF;
        case (m)
            M_D3: if (op == 16'h00D3) begin
                case (idx)
                    0: r = 8'h00;
                    1: r = 8'h00;
                    2: r = 8'h93;
                    3: r = 8'h41;
                    default: r = 8'hFF;
                endcase
            end
            M_A1: if (op == 16'h00A1) begin
                case (idx)
                    0: r = 8'h01;
                    1: r = 8'h57;
                    2: r = 8'h61;
                    3: r = 8'h01;
                    default: r = 8'hFF;
                endcase
            end
            M_DB: if (op == 16'hDB00 && idx == 0) r = 8'h80;
            default: r = 8'hFF;
        endcase
        return r;
    endfunction

    // Floating bus reads 0xFFFF; upper byte is junk the DUT must ignore
    assign bus.lcd_data_in = bus.lcd_rd_n ? 16'hFFFF : {8'hA5, resp_byte(mode, cur_op, rd_idx)};

    // Panel model and strobe-width collector, sampled mid-cycle
    always @(negedge clk_50m) begin
        if (!rst_n) begin
            cur_op   = 16'h0000;
            rd_idx   = 0;
            xfers    = 0;
            seen_d4  = 1'b0;
            wr_low   = 0;
            rd_low   = 0;
            oe_in_rd = 1'b0;
            wr_prev  = 1'b1;
            rd_prev  = 1'b1;
        end else begin
            if (!bus.lcd_wr_n) begin
                wr_low++;
            end else if (!wr_prev) begin
                wr_w_q.push_back(wr_low);
                wr_low = 0;
                if (!bus.lcd_cs_n && !bus.lcd_rs) begin
                    cur_op = bus.lcd_data_out;
                    rd_idx = 0;
                    xfers++;
                    if (cur_op == 16'h00D4) seen_d4 = 1'b1;
                end
            end
            if (!bus.lcd_rd_n) begin
                rd_low++;
                if (bus.lcd_data_oe) oe_in_rd = 1'b1;
            end else if (!rd_prev) begin
                rd_w_q.push_back(rd_low);
                rd_oe_q.push_back(oe_in_rd);
                rd_low   = 0;
                oe_in_rd = 1'b0;
                rd_idx++;
                xfers++;
            end
            wr_prev = bus.lcd_wr_n;
            rd_prev = bus.lcd_rd_n;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drain_timing();
        while (wr_w_q.size() > 0) check_eq("wr_low_width", wr_w_q.pop_front(), WR_LOW_CYC);
        while (rd_w_q.size() > 0) check_eq("rd_low_width", rd_w_q.pop_front(), RD_LOW_CYC);
        while (rd_oe_q.size() > 0) check_eq("oe_during_rd", {31'd0, rd_oe_q.pop_front()}, 0);
    endtask

    task automatic wait_valid(output bit ok);
        int n;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 5000) begin
            @(negedge clk_50m);
            if (id_valid === 1'b1) ok = 1'b1;
            n++;
        end
    endtask

    // Waits for the result and checks it against the head of the scoreboard
    task automatic collect_result();
        bit   ok;
        exp_t e;
        wait_valid(ok);
        if (sb_q.size() == 0) begin
            check_eq("sb_empty", 1, 0);
        end else begin
            e = sb_q.pop_front();
            if (!ok) begin
                check_eq({e.name, "_valid_timeout"}, 0, 1);
            end else begin
                $display("txn %s: lcd_id=%h id_err=%0d xfers=%0d last_op=%h",
                         e.name, lcd_id, id_err, xfers, cur_op);
                check_eq({e.name, "_id"}, lcd_id, e.id);
                check_eq({e.name, "_err"}, id_err, e.err);
                check_eq({e.name, "_xfers"}, xfers, e.xfers);
                check_eq({e.name, "_last_op"}, cur_op, e.last_op);
                check_eq({e.name, "_seen_d4"}, seen_d4, e.d4);
                repeat (20) @(negedge clk_50m);
                check_eq({e.name, "_id_stable"}, lcd_id, e.id);
                check_eq({e.name, "_valid_stable"}, id_valid, 1);
                check_eq({e.name, "_released"},
                         {bus.lcd_cs_n, bus.lcd_data_oe, bus.lcd_wr_n, bus.lcd_rd_n}, 4'b1011);
            end
        end
        drain_timing();
    endtask

    task automatic run_case(input string name, input int m, input logic [15:0] id,
                            input logic err, input int nx, input logic [15:0] last_op,
                            input logic d4);
        exp_t e;
        rst_n = 1'b0;
        mode  = m;
        repeat (2) @(negedge clk_50m);
        e.name = name; e.id = id; e.err = err; e.xfers = nx; e.last_op = last_op; e.d4 = d4;
        sb_q.push_back(e);
        rst_n = 1'b1;
        repeat (5) @(negedge clk_50m);
        check_eq({name, "_pwrup_cs"}, bus.lcd_cs_n, 1);
        collect_result();
    endtask

    initial begin
        bit   ok;
        int   n;
        exp_t e;
        total = 0;
        bad   = 0;
        mode  = M_D3;
        rst_n = 1'b0;
        repeat (3) @(posedge clk_50m);
        #1;
        check_eq("rst_cs_n", bus.lcd_cs_n, 1);
        check_eq("rst_rs", bus.lcd_rs, 1);
        check_eq("rst_wr_n", bus.lcd_wr_n, 1);
        check_eq("rst_rd_n", bus.lcd_rd_n, 1);
        check_eq("rst_oe", bus.lcd_data_oe, 0);
        check_eq("rst_data_out", bus.lcd_data_out, 0);
        check_eq("rst_lcd_id", lcd_id, 0);
        check_eq("rst_valid", id_valid, 0);
        check_eq("rst_err", id_err, 0);

        run_case("p9341", M_D3, 16'h9341, 1'b0, 5, 16'h00D3, 1'b0);
        run_case("p1963", M_A1, 16'h1963, 1'b0, 18, 16'h00A1, 1'b1);
        run_case("p5510", M_DB, 16'h5510, 1'b0, 12, 16'hDB00, 1'b1);
        run_case("float", M_FLT, 16'h0000, 1'b1, 18 * PASSES, 16'h00A1, 1'b1);

        // Reset pulsed while rd_n is low, then a clean second run
        rst_n = 1'b0;
        mode  = M_D3;
        repeat (2) @(negedge clk_50m);
        rst_n = 1'b1;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 2000) begin
            @(negedge clk_50m);
            if (bus.lcd_rd_n === 1'b0) ok = 1'b1;
            n++;
        end
        check_eq("midrd_seen_rd", ok, 1);
        repeat (3) @(negedge clk_50m);
        check_eq("midrd_rd_low_before", bus.lcd_rd_n, 0);
        rst_n = 1'b0;
        #1;
        check_eq("midrd_rd_n_async", bus.lcd_rd_n, 1);
        check_eq("midrd_cs_n_async", bus.lcd_cs_n, 1);
        check_eq("midrd_oe_async", bus.lcd_data_oe, 0);
        repeat (2) @(negedge clk_50m);
        e.name = "rerun"; e.id = 16'h9341; e.err = 1'b0; e.xfers = 5; e.last_op = 16'h00D3; e.d4 = 1'b0;
        sb_q.push_back(e);
        rst_n = 1'b1;
        collect_result();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
